// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default timing for the PWM duty-step button conditioner.
// Holds the per-button FSM state enum and the counter-width helper.
package pwm_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMING,
      ST_PRESSED,
      ST_REPEATING,
      ST_RELEASING
   } btn_state_t;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_REPEAT_DELAY    = 16;
   localparam int DEF_REPEAT_PERIOD   = 8;

   // One shared counter per channel must reach the largest of the three targets.
   function automatic int cnt_width(input int deb, input int rdel, input int rper);
      int m;
      m = deb;
      if (rdel > m) m = rdel;
      if (rper > m) m = rper;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: synchroniser, debounce / auto-repeat FSM and its counter.
// fire is a combinational one-cycle strobe; the top level registers it.
module button_channel
   import pwm_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic btn,
   output logic fire,
   output logic held
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] RD_C  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RP_C  = CNT_W'(REPEAT_PERIOD);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s;
   btn_state_t             state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next, cnt_inc;

   // The synchroniser only honours rst_n so it keeps tracking the pin while disabled.
   always_ff @(posedge clk) begin
      if (!rst_n) sync_reg <= '0;
      else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn};
   end

   assign s       = sync_reg[SYNC_STAGES-1];
   assign cnt_inc = cnt_reg + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      fire       = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            cnt_next = '0;
            if (s) begin
               state_next = ST_ARMING;
               cnt_next   = CNT_W'(1);
            end
         end
         ST_ARMING: begin
            if (!s) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == DEB_C) begin
               state_next = ST_PRESSED;
               cnt_next   = '0;
               fire       = 1'b1;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         ST_PRESSED, ST_REPEATING: begin
            if (!s) begin
               // The first low sample already counts towards release.
               if (DEBOUNCE_CYCLES <= 1) begin
                  state_next = ST_IDLE;
                  cnt_next   = '0;
               end else begin
                  state_next = ST_RELEASING;
                  cnt_next   = CNT_W'(1);
               end
            end else if (state_reg == ST_REPEATING) begin
               if (cnt_inc == RP_C) begin
                  cnt_next = '0;
                  fire     = 1'b1;
               end else begin
                  cnt_next = cnt_inc;
               end
            end else if (REPEAT_DELAY != 0) begin
               if (cnt_inc == RD_C) begin
                  state_next = ST_REPEATING;
                  cnt_next   = '0;
                  fire       = 1'b1;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         ST_RELEASING: begin
            if (s) begin
               state_next = ST_PRESSED;
               cnt_next   = '0;
            end else if (cnt_inc == DEB_C) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign held = (state_reg == ST_PRESSED) || (state_reg == ST_REPEATING) ||
                 (state_reg == ST_RELEASING);

endmodule

// File: rtl/pwm_button_conditioner.sv
// Conditions the increase/decrease duty buttons into clean one-cycle step pulses.
// Adds enable gating, inc/dec collision suppression and the output pulse registers.
module pwm_button_conditioner
   import pwm_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic ui_increase_duty,
   input  logic ui_decrease_duty,
   output logic inc_pulse,
   output logic dec_pulse,
   output logic inc_held,
   output logic dec_held
);

   logic [1:0] btn_raw;
   logic [1:0] fire;
   logic [1:0] held;
   logic       inc_pulse_reg, inc_pulse_next;
   logic       dec_pulse_reg, dec_pulse_next;

   assign btn_raw = {ui_decrease_duty, ui_increase_duty};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
         ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (~ena),
            .btn  (btn_raw[gi]),
            .fire (fire[gi]),
            .held (held[gi])
         );
      end
   endgenerate

   // Simultaneous steps in both directions cancel; the FSMs are unaffected.
   always_comb begin
      inc_pulse_next = fire[0] & ~fire[1];
      dec_pulse_next = fire[1] & ~fire[0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n || !ena) begin
         inc_pulse_reg <= 1'b0;
         dec_pulse_reg <= 1'b0;
      end else begin
         inc_pulse_reg <= inc_pulse_next;
         dec_pulse_reg <= dec_pulse_next;
      end
   end

   assign inc_pulse = inc_pulse_reg & ena;
   assign dec_pulse = dec_pulse_reg & ena;
   assign inc_held  = held[0] & ena;
   assign dec_held  = held[1] & ena;

endmodule

// File: tb/tb_pwm_button_conditioner.sv
// Directed plus randomized bench for pwm_button_conditioner against a run-length
// reference model; a second instance is built with auto-repeat disabled.
module tb_pwm_button_conditioner;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int RD   = 16;
   localparam int RP   = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b0;
   logic inc_raw = 1'b0;
   logic dec_raw = 1'b0;
   logic inc_pulse, dec_pulse, inc_held, dec_held;
   logic nr_inc_pulse, nr_dec_pulse, nr_inc_held, nr_dec_held;

   always #5 clk = ~clk;

   pwm_button_conditioner dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .ui_increase_duty(inc_raw), .ui_decrease_duty(dec_raw),
      .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
      .inc_held(inc_held), .dec_held(dec_held)
   );

   pwm_button_conditioner #(.REPEAT_DELAY(0)) dut_nr (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .ui_increase_duty(inc_raw), .ui_decrease_duty(dec_raw),
      .inc_pulse(nr_inc_pulse), .dec_pulse(nr_dec_pulse),
      .inc_held(nr_inc_held), .dec_held(nr_dec_held)
   );

   int errors = 0;
   int checks = 0;

   // Reference model, index k = config*2 + channel (config 1 has no auto-repeat).
   // lvl: debounced level; run: consecutive samples disagreeing with lvl;
   // since: high samples since the last step pulse; rep: already repeating.
   int               m_lvl[4];
   int               m_run[4];
   int               m_since[4];
   int               m_rep[4];
   logic [SYNC-1:0]  m_sync[4];
   logic             exp_pulse[4];
   logic             exp_held[4];

   int rel;
   int inc_q[$];
   int dec_q[$];
   int nr_inc_n, nr_dec_n;
   int last_inc_held;

   task automatic model_chan(input int k, input int rd, input logic clear, output logic fire);
      logic s;
      logic raw;
      s   = m_sync[k][SYNC-1];
      raw = (k % 2 == 0) ? inc_raw : dec_raw;
      if (!rst_n) m_sync[k] = '0;
      else        m_sync[k] = {m_sync[k][SYNC-2:0], raw};
      fire = 1'b0;
      if (clear) begin
         m_lvl[k] = 0; m_run[k] = 0; m_since[k] = 0; m_rep[k] = 0;
      end else if (m_lvl[k] == 0) begin
         if (s) begin
            m_run[k]++;
            if (m_run[k] == DEB + 1) begin
               fire = 1'b1;
               m_lvl[k] = 1; m_run[k] = 0; m_since[k] = 0; m_rep[k] = 0;
            end
         end else begin
            m_run[k] = 0;
         end
      end else if (!s) begin
         m_run[k]++;
         m_since[k] = 0;
         m_rep[k] = 0;
         if (m_run[k] >= DEB) begin
            m_lvl[k] = 0; m_run[k] = 0;
         end
      end else if (m_run[k] > 0) begin
         m_run[k] = 0;
         m_since[k] = 0;
      end else if (rd != 0) begin
         m_since[k]++;
         if (m_since[k] == ((m_rep[k] != 0) ? RP : rd)) begin
            fire = 1'b1;
            m_since[k] = 0;
            m_rep[k] = 1;
         end
      end
   endtask

   task automatic model_edge();
      logic clear;
      logic f[4];
      clear = !rst_n || !ena;
      model_chan(0, RD, clear, f[0]);
      model_chan(1, RD, clear, f[1]);
      model_chan(2, 0,  clear, f[2]);
      model_chan(3, 0,  clear, f[3]);
      for (int c = 0; c < 2; c++) begin
         exp_pulse[c*2]   = f[c*2] & ~f[c*2+1];
         exp_pulse[c*2+1] = f[c*2+1] & ~f[c*2];
      end
      for (int k = 0; k < 4; k++) exp_held[k] = (m_lvl[k] != 0) && ena;
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b rel=%0d t=%0t", tag, obs, exp, rel, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic begin_phase();
      rel = 0;
      inc_q.delete();
      dec_q.delete();
      nr_inc_n = 0;
      nr_dec_n = 0;
      last_inc_held = -1;
   endtask

   task automatic step(input logic i_v, input logic d_v, input logic r_v, input logic e_v);
      @(negedge clk);
      inc_raw = i_v;
      dec_raw = d_v;
      rst_n   = r_v;
      ena     = e_v;
      @(posedge clk);
      model_edge();
      #1;
      check_bit("inc_pulse",    inc_pulse,    exp_pulse[0]);
      check_bit("dec_pulse",    dec_pulse,    exp_pulse[1]);
      check_bit("inc_held",     inc_held,     exp_held[0]);
      check_bit("dec_held",     dec_held,     exp_held[1]);
      check_bit("nr_inc_pulse", nr_inc_pulse, exp_pulse[2]);
      check_bit("nr_dec_pulse", nr_dec_pulse, exp_pulse[3]);
      check_bit("nr_inc_held",  nr_inc_held,  exp_held[2]);
      check_bit("nr_dec_held",  nr_dec_held,  exp_held[3]);
      if (inc_pulse === 1'b1) inc_q.push_back(rel);
      if (dec_pulse === 1'b1) dec_q.push_back(rel);
      if (nr_inc_pulse === 1'b1) nr_inc_n++;
      if (nr_dec_pulse === 1'b1) nr_dec_n++;
      if (inc_held === 1'b1) last_inc_held = rel;
      rel++;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   function automatic int first_of(input int q[$]);
      return (q.size() > 0) ? q[0] : -1;
   endfunction

   initial begin
      logic ir, dr, rr, er;
      int   bounce[9];
      int   rel_chatter[3];
      for (int k = 0; k < 4; k++) begin
         m_lvl[k] = 0; m_run[k] = 0; m_since[k] = 0; m_rep[k] = 0; m_sync[k] = '0;
      end
      bounce      = '{1, 1, 0, 1, 0, 1, 1, 1, 1};
      rel_chatter = '{0, 1, 0};

      // Reset with the button already held; first pulse 7 cycles after release.
      begin_phase();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      check_int("reset_no_pulse", inc_q.size(), 0);
      begin_phase();
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
      check_int("reset_first_pulse_rel", first_of(inc_q), 6);
      idle_steps(12);
      $display("phase reset: inc pulses=%0d", inc_q.size());

      // Clean press of 12 cycles.
      begin_phase();
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
      idle_steps(12);
      check_int("clean_count", inc_q.size(), 1);
      check_int("clean_first_rel", first_of(inc_q), 6);
      check_int("clean_last_held", last_inc_held, 16);
      check_int("clean_no_dec", dec_q.size(), 0);
      $display("phase clean: inc pulses=%0d last held rel=%0d", inc_q.size(), last_inc_held);

      // Bouncy press and chattering release.
      begin_phase();
      foreach (bounce[i]) step(bounce[i][0], 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
      foreach (rel_chatter[i]) step(rel_chatter[i][0], 1'b0, 1'b1, 1'b1);
      idle_steps(12);
      check_int("bounce_count", inc_q.size(), 1);
      $display("phase bounce: inc pulses=%0d", inc_q.size());

      // Hold decrease: pulses at 7, 23, 31, 39; one pulse without auto-repeat.
      begin_phase();
      for (int i = 0; i < 42; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
      idle_steps(12);
      check_int("repeat_count", dec_q.size(), 4);
      check_int("repeat_p0", (dec_q.size() > 0) ? dec_q[0] : -1, 6);
      check_int("repeat_p1", (dec_q.size() > 1) ? dec_q[1] : -1, 22);
      check_int("repeat_p2", (dec_q.size() > 2) ? dec_q[2] : -1, 30);
      check_int("repeat_p3", (dec_q.size() > 3) ? dec_q[3] : -1, 38);
      check_int("norepeat_count", nr_dec_n, 1);
      $display("phase repeat: dec pulses=%0d norepeat=%0d", dec_q.size(), nr_dec_n);

      // Both buttons rise together: suppressed.
      begin_phase();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
      idle_steps(12);
      check_int("collide_inc", inc_q.size(), 0);
      check_int("collide_dec", dec_q.size(), 0);
      $display("phase collision: inc=%0d dec=%0d", inc_q.size(), dec_q.size());

      // Press while disabled, then enable with the button still held.
      begin_phase();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      check_int("ena_off_count", inc_q.size(), 0);
      begin_phase();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
      check_int("ena_on_first_rel", first_of(inc_q), 4);
      idle_steps(12);
      $display("phase ena: first pulse rel=%0d", first_of(inc_q));

      // Reset for one cycle while repeating, button still held.
      begin_phase();
      for (int i = 0; i < 26; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check_bit("midrst_dec_held", dec_held, 1'b0);
      check_bit("midrst_dec_pulse", dec_pulse, 1'b0);
      begin_phase();
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
      check_int("midrst_first_rel", first_of(dec_q), 6);
      idle_steps(12);
      $display("phase midreset: first pulse rel=%0d", first_of(dec_q));

      // Randomized bouncy buttons with occasional disable and reset.
      begin_phase();
      ir = 1'b0; dr = 1'b0; rr = 1'b1; er = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 11) == 0) ir = ~ir;
         if ($urandom_range(0, 13) == 0) dr = ~dr;
         if ($urandom_range(0, 59) == 0) er = ~er;
         rr = ($urandom_range(0, 199) != 0);
         step(ir, dr, rr, er);
      end
      idle_steps(12);
      $display("phase random: inc pulses=%0d dec pulses=%0d", inc_q.size(), dec_q.size());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
